// File: rtl/render_scheduler.sv
// Frame sequencer: once per frame period it snapshots the pose, runs draw_fpv then the
// minimap drawer, and routes the shared grid/VGA ports to whichever client is active.
module render_scheduler #(
  parameter int FRAME_TICKS = 833333,
  parameter int WATCHDOG    = 262143
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [13:0] player_pos_x_in,
  input  logic [12:0] player_pos_y_in,
  input  logic [7:0]  player_angle_in,
  output logic [13:0] player_pos_x,
  output logic [12:0] player_pos_y,
  output logic [7:0]  player_angle,
  output logic        fpv_start,
  input  logic        fpv_done,
  input  logic [5:0]  fpv_grid_x,
  input  logic [4:0]  fpv_grid_y,
  input  logic [7:0]  fpv_vga_x,
  input  logic [6:0]  fpv_vga_y,
  input  logic [17:0] fpv_vga_colour,
  input  logic        fpv_vga_write,
  output logic        map_start,
  input  logic        map_done,
  input  logic [5:0]  map_grid_x,
  input  logic [4:0]  map_grid_y,
  input  logic [7:0]  map_vga_x,
  input  logic [6:0]  map_vga_y,
  input  logic [17:0] map_vga_colour,
  input  logic        map_vga_write,
  output logic [5:0]  grid_x,
  output logic [4:0]  grid_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [17:0] vga_colour,
  output logic        vga_write,
  output logic        frame_done,
  output logic        overrun,
  output logic        timeout,
  output logic        busy
);

  localparam int TW = $clog2(FRAME_TICKS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_TICKS - 1);
  // Abort on the cycle whose increment would bring the watchdog to WATCHDOG.
  localparam logic [17:0] WD_LAST = 18'(WATCHDOG - 1);

  typedef enum logic [2:0] {
    IDLE, SNAPSHOT, START_FPV, WAIT_FPV, START_MAP, WAIT_MAP, FRAME_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [17:0]   wd_q, wd_d;
  logic          timeout_q, timeout_d;
  logic [13:0]   pos_x_q, pos_x_d;
  logic [12:0]   pos_y_q, pos_y_d;
  logic [7:0]    angle_q, angle_d;

  logic          tick;
  logic          launch;
  logic [17:0]   wd_inc;
  logic          wd_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= 1'b0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      angle_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      angle_q   <= angle_d;
    end
  end

  assign tick    = (timer_q == TIMER_LAST);
  assign timer_d = tick ? '0 : timer_q + 1'b1;
  assign launch  = (state_q == IDLE) && enable && pending_q;
  // A tick landing on the launch cycle belongs to the next frame, so it wins.
  assign pending_d = tick | (pending_q & ~launch);
  assign overrun   = tick & pending_q;
  assign wd_inc    = (wd_q == '1) ? wd_q : wd_q + 18'd1;
  assign wd_hit    = (wd_q >= WD_LAST);

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    timeout_d  = timeout_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    angle_d    = angle_q;
    fpv_start  = 1'b0;
    map_start  = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (launch) state_d = SNAPSHOT;
      end
      SNAPSHOT: begin
        pos_x_d = player_pos_x_in;
        pos_y_d = player_pos_y_in;
        angle_d = player_angle_in;
        state_d = START_FPV;
      end
      START_FPV: begin
        fpv_start = 1'b1;
        wd_d      = '0;
        state_d   = WAIT_FPV;
      end
      WAIT_FPV: begin
        wd_d = wd_inc;
        if (fpv_done) begin
          state_d = START_MAP;
        end else if (wd_hit) begin
          state_d   = START_MAP;
          timeout_d = 1'b1;
        end
      end
      START_MAP: begin
        map_start = 1'b1;
        wd_d      = '0;
        state_d   = WAIT_MAP;
      end
      WAIT_MAP: begin
        wd_d = wd_inc;
        if (map_done) begin
          state_d = FRAME_DONE;
        end else if (wd_hit) begin
          state_d   = FRAME_DONE;
          timeout_d = 1'b1;
        end
      end
      FRAME_DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus ownership follows the FSM state directly, so reset drops it at once.
  always_comb begin
    grid_x     = '0;
    grid_y     = '0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_write  = 1'b0;
    case (state_q)
      START_FPV, WAIT_FPV: begin
        grid_x     = fpv_grid_x;
        grid_y     = fpv_grid_y;
        vga_x      = fpv_vga_x;
        vga_y      = fpv_vga_y;
        vga_colour = fpv_vga_colour;
        vga_write  = fpv_vga_write;
      end
      START_MAP, WAIT_MAP: begin
        grid_x     = map_grid_x;
        grid_y     = map_grid_y;
        vga_x      = map_vga_x;
        vga_y      = map_vga_y;
        vga_colour = map_vga_colour;
        vga_write  = map_vga_write;
      end
      default: ;
    endcase
  end

  assign player_pos_x = pos_x_q;
  assign player_pos_y = pos_y_q;
  assign player_angle = angle_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench: instance A (100-cycle frames, watchdog 50) covers sequencing, pose,
// ownership, watchdog and reset; instance B (30-cycle frames) covers overrun.
module tb_render_scheduler;

  logic clk, rst_n;
  int   cyc;
  int   n_checks, n_pass;

  // Instance A
  logic        en_a;
  logic [13:0] px_in;
  logic [12:0] py_in;
  logic [7:0]  pa_in;
  logic [13:0] px_a;
  logic [12:0] py_a;
  logic [7:0]  pa_a;
  logic        fpv_start_a, fpv_done_a, map_start_a, map_done_a;
  logic        fwr, mwr;
  logic [5:0]  grid_x_a;
  logic [4:0]  grid_y_a;
  logic [7:0]  vga_x_a;
  logic [6:0]  vga_y_a;
  logic [17:0] vga_col_a;
  logic        vga_wr_a, frame_done_a, overrun_a, timeout_a, busy_a;
  int          fpv_lat_a, map_lat_a;

  // Instance B
  logic        fpv_start_b, fpv_done_b, map_start_b, map_done_b;
  logic [13:0] px_b;
  logic [12:0] py_b;
  logic [7:0]  pa_b;
  logic [5:0]  grid_x_b;
  logic [4:0]  grid_y_b;
  logic [7:0]  vga_x_b;
  logic [6:0]  vga_y_b;
  logic [17:0] vga_col_b;
  logic        vga_wr_b, frame_done_b, overrun_b, timeout_b, busy_b;

  int fs_a[$], ms_a[$], fd_a[$], fs_b[$], ov_b[$];
  int busy_cnt_a;

  localparam logic [17:0] FCOL = 18'h2AAAA;
  localparam logic [17:0] MCOL = 18'h15555;

  render_scheduler #(.FRAME_TICKS(100), .WATCHDOG(50)) u_a (
    .clock(clk), .reset(rst_n), .enable(en_a),
    .player_pos_x_in(px_in), .player_pos_y_in(py_in), .player_angle_in(pa_in),
    .player_pos_x(px_a), .player_pos_y(py_a), .player_angle(pa_a),
    .fpv_start(fpv_start_a), .fpv_done(fpv_done_a),
    .fpv_grid_x(6'h2A), .fpv_grid_y(5'h15), .fpv_vga_x(8'hA1), .fpv_vga_y(7'h51),
    .fpv_vga_colour(FCOL), .fpv_vga_write(fwr),
    .map_start(map_start_a), .map_done(map_done_a),
    .map_grid_x(6'h15), .map_grid_y(5'h0A), .map_vga_x(8'h1A), .map_vga_y(7'h2B),
    .map_vga_colour(MCOL), .map_vga_write(mwr),
    .grid_x(grid_x_a), .grid_y(grid_y_a), .vga_x(vga_x_a), .vga_y(vga_y_a),
    .vga_colour(vga_col_a), .vga_write(vga_wr_a),
    .frame_done(frame_done_a), .overrun(overrun_a), .timeout(timeout_a), .busy(busy_a)
  );

  render_scheduler #(.FRAME_TICKS(30), .WATCHDOG(262143)) u_b (
    .clock(clk), .reset(rst_n), .enable(1'b1),
    .player_pos_x_in(14'd0), .player_pos_y_in(13'd0), .player_angle_in(8'd0),
    .player_pos_x(px_b), .player_pos_y(py_b), .player_angle(pa_b),
    .fpv_start(fpv_start_b), .fpv_done(fpv_done_b),
    .fpv_grid_x(6'd0), .fpv_grid_y(5'd0), .fpv_vga_x(8'd0), .fpv_vga_y(7'd0),
    .fpv_vga_colour(18'd0), .fpv_vga_write(1'b0),
    .map_start(map_start_b), .map_done(map_done_b),
    .map_grid_x(6'd0), .map_grid_y(5'd0), .map_vga_x(8'd0), .map_vga_y(7'd0),
    .map_vga_colour(18'd0), .map_vga_write(1'b0),
    .grid_x(grid_x_b), .grid_y(grid_y_b), .vga_x(vga_x_b), .vga_y(vga_y_b),
    .vga_colour(vga_col_b), .vga_write(vga_wr_b),
    .frame_done(frame_done_b), .overrun(overrun_b), .timeout(timeout_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int qcount_below(input int q[$], input int lim);
    int n = 0;
    foreach (q[i]) if (q[i] < lim) n++;
    return n;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Client models: done pulses a fixed number of cycles after the start pulse (0 = never).
  initial begin
    int fc, mc;
    fc = 0; mc = 0; fpv_done_a = 1'b0; map_done_a = 1'b0;
    forever begin
      @(negedge clk);
      fpv_done_a = 1'b0;
      map_done_a = 1'b0;
      if (fc > 0) begin fc--; if (fc == 0) fpv_done_a = 1'b1; end
      if (mc > 0) begin mc--; if (mc == 0) map_done_a = 1'b1; end
      if (fpv_start_a && fpv_lat_a > 0) fc = fpv_lat_a;
      if (map_start_a && map_lat_a > 0) mc = map_lat_a;
    end
  end

  initial begin
    int fc, mc;
    fc = 0; mc = 0; fpv_done_b = 1'b0; map_done_b = 1'b0;
    forever begin
      @(negedge clk);
      fpv_done_b = 1'b0;
      map_done_b = 1'b0;
      if (fc > 0) begin fc--; if (fc == 0) fpv_done_b = 1'b1; end
      if (mc > 0) begin mc--; if (mc == 0) map_done_b = 1'b1; end
      if (fpv_start_b) fc = 33;
      if (map_start_b) mc = 33;
    end
  end

  // Event recorder: cycle n is the period after the n-th rising edge since reset release.
  initial begin
    cyc = 0;
    busy_cnt_a = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (fpv_start_a)  fs_a.push_back(cyc);
      if (map_start_a)  ms_a.push_back(cyc);
      if (frame_done_a) fd_a.push_back(cyc);
      if (busy_a)       busy_cnt_a++;
      if (fpv_start_b)  fs_b.push_back(cyc);
      if (overrun_b)    ov_b.push_back(cyc);
    end
  end

  initial begin
    #20000;
    $display("FAIL sim_time_limit: got expired expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int nfs, nb;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; en_a = 1'b1;
    px_in = 14'h1234; py_in = 13'h0ABC; pa_in = 8'h5A;
    fwr = 1'b1; mwr = 1'b1;
    fpv_lat_a = 20; map_lat_a = 10;

    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy_a, 0);
    check("rst_fpv_start", fpv_start_a, 0);
    check("rst_frame_done", frame_done_a, 0);
    check("rst_overrun", overrun_a, 0);
    check("rst_timeout", timeout_a, 0);
    check("rst_pos_x", px_a, 0);
    check("rst_vga_write", vga_wr_a, 0);
    check("rst_vga_colour", vga_col_a, 0);
    check("rst_grid_x", grid_x_a, 0);
    rst_n = 1'b1;
    cyc = 0;

    // Frame 1: tick at 99, fpv_start at 102, map_start at 123, frame_done at 134.
    wait_cyc(100);
    check("idle_vga_write", vga_wr_a, 0);
    check("idle_grid_x", grid_x_a, 0);
    check("idle_grid_y", grid_y_a, 0);
    check("idle_busy", busy_a, 0);
    check("pose_before_snap", px_a, 0);
    wait_cyc(101);
    check("snap_busy", busy_a, 1);
    check("snap_vga_write", vga_wr_a, 0);
    check("snap_fpv_start", fpv_start_a, 0);
    wait_cyc(102);
    check("fpv_start_lat", fpv_start_a, 1);
    check("fpv_vga_write", vga_wr_a, 1);
    check("fpv_colour", vga_col_a, FCOL);
    check("fpv_grid_x", grid_x_a, 6'h2A);
    check("snap_pos_x", px_a, 14'h1234);
    check("snap_pos_y", py_a, 13'h0ABC);
    wait_cyc(110);
    px_in = 14'h0321; py_in = 13'h1111; pa_in = 8'hC3;
    wait_cyc(115);
    fwr = 1'b0;
    #1;
    check("fpv_owner_write_low", vga_wr_a, 0);
    fwr = 1'b1;
    wait_cyc(122);
    check("wait_fpv_colour", vga_col_a, FCOL);
    check("no_early_map_start", map_start_a, 0);
    wait_cyc(123);
    check("map_start_lat", map_start_a, 1);
    check("map_colour", vga_col_a, MCOL);
    check("map_grid_y", grid_y_a, 5'h0A);
    check("map_vga_x", vga_x_a, 8'h1A);
    wait_cyc(125);
    mwr = 1'b0;
    #1;
    check("nonowner_fpv_write", vga_wr_a, 0);
    mwr = 1'b1;
    wait_cyc(130);
    check("hold_pos_x", px_a, 14'h1234);
    check("hold_angle", pa_a, 8'h5A);
    wait_cyc(134);
    check("frame_done_lat", frame_done_a, 1);
    check("fdone_vga_write", vga_wr_a, 0);
    wait_cyc(135);
    check("post_frame_busy", busy_a, 0);
    check("timeout_clear", timeout_a, 0);

    // Frame 2 picks up the pose changed during frame 1.
    wait_cyc(201);
    check("pose_until_snap", px_a, 14'h1234);
    wait_cyc(202);
    check("new_pos_x", px_a, 14'h0321);
    check("new_pos_y", py_a, 13'h1111);
    check("new_angle", pa_a, 8'hC3);
    wait_cyc(240);
    check("fs0", qget(fs_a, 0), 102);
    check("ms0", qget(ms_a, 0), 123);
    check("fd0", qget(fd_a, 0), 134);
    check("fd1", qget(fd_a, 1), 234);
    check("ms1", qget(ms_a, 1), 223);

    // Frame 3: fpv_done lands exactly on the watchdog limit cycle.
    fpv_lat_a = 50;
    wait_cyc(360);
    check("fs2", qget(fs_a, 2), 302);
    check("limit_done_ms2", qget(ms_a, 2), 353);
    check("limit_done_timeout", timeout_a, 0);
    wait_cyc(365);
    check("fd2", qget(fd_a, 2), 364);

    // Frame 4: fpv never finishes; abort 50 cycles after WAIT_FPV entry (403).
    fpv_lat_a = 0;
    wait_cyc(452);
    check("wd_pre_timeout", timeout_a, 0);
    check("wd_pre_map_start", map_start_a, 0);
    wait_cyc(453);
    check("wd_map_start", map_start_a, 1);
    check("wd_timeout", timeout_a, 1);
    wait_cyc(470);
    fpv_lat_a = 20;
    check("fd3", qget(fd_a, 3), 464);

    wait_cyc(520);
    check("timeout_sticky", timeout_a, 1);
    check("b_fs0", qget(fs_b, 0), 32);
    check("b_overrun_at", qget(ov_b, 0), 89);
    check("b_overrun_once", qcount_below(ov_b, 119), 1);
    check("b_relaunch", qget(fs_b, 1), 103);

    // Frame 5 is in WAIT_MAP at 528; reset there and release with enable low.
    wait_cyc(528);
    check("fs4", qget(fs_a, 4), 502);
    check("ms4", qget(ms_a, 4), 523);
    check("in_wait_map_busy", busy_a, 1);
    rst_n = 1'b0;
    en_a = 1'b0;
    #1;
    check("midrst_busy", busy_a, 0);
    check("midrst_vga_write", vga_wr_a, 0);
    check("midrst_vga_colour", vga_col_a, 0);
    check("midrst_grid_x", grid_x_a, 0);
    check("midrst_timeout", timeout_a, 0);
    check("midrst_pos_x", px_a, 0);
    check("midrst_map_start", map_start_a, 0);
    wait_cyc(531);
    rst_n = 1'b1;
    nfs = fs_a.size();
    nb = busy_cnt_a;
    wait_cyc(781);
    check("disabled_no_start", fs_a.size(), nfs);
    check("disabled_no_busy", busy_cnt_a, nb);
    check("disabled_pos_x", px_a, 0);
    en_a = 1'b1;
    wait_cyc(790);
    check("pending_held_launch", qget(fs_a, nfs), 783);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
